// File: rtl/rx_pkg.sv
// Purpose: shared UART types and helpers for the receiver (and the matching transmitter).
// Contents:
//   rx_state_e    receiver FSM state encoding
//   BitCyclesDef  default clk cycles per bit period
//   HalfCyclesDef default clk cycles from the start edge to the start-bit centre
//   odd_parity()  parity bit that makes the total count of ones odd
package rx_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StStart = 3'd1,
    StBits  = 3'd2,
    StPar   = 3'd3,
    StStop  = 3'd4
  } rx_state_e;

  localparam int unsigned BitCyclesDef  = 5209;
  localparam int unsigned HalfCyclesDef = 2604;

  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/rx_if.sv
// Purpose: serial input and consumer handshake for the UART receiver.
// Signals:
//   Sin        serial line into the receiver (idles high)
//   ReceiveAck consumer acknowledge, level
//   Received   byte available, held until acknowledged
//   Dout       received byte
//   parityErr  odd-parity check failed
//   frameErr   stop bit sampled low
//   overrun    a frame completed while Received was still high
// Modports: slave = receiver side, master = line driver / consumer side.
interface rx_if;
  logic       Sin;
  logic       ReceiveAck;
  logic       Received;
  logic [7:0] Dout;
  logic       parityErr;
  logic       frameErr;
  logic       overrun;

  modport slave (
    input  Sin,
    input  ReceiveAck,
    output Received,
    output Dout,
    output parityErr,
    output frameErr,
    output overrun
  );

  modport master (
    output Sin,
    output ReceiveAck,
    input  Received,
    input  Dout,
    input  parityErr,
    input  frameErr,
    input  overrun
  );
endinterface

// File: rtl/rx_sync2.sv
// Purpose: two-flop synchronizer for an asynchronous single-bit input.
// Ports:
//   clk    system clock
//   Reset  synchronous active-high reset; both flops load RESET_VAL
//   i_d    asynchronous input
//   o_q    synchronized output
module rx_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic Reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/rx.sv
// Purpose: UART receiver. Frame: start(0), 8 data bits LSB first, odd parity, stop(1).
//   Each bit is sampled at its centre; the byte and status flags are presented with a
//   level handshake (Received held until ReceiveAck).
// Ports:
//   clk    system clock
//   Reset  synchronous active-high reset
//   bus    rx_if.slave: Sin, ReceiveAck in; Received, Dout, parityErr, frameErr, overrun out
module rx
  import rx_pkg::*;
#(
  parameter int unsigned BIT_CYCLES  = BitCyclesDef,
  parameter int unsigned HALF_CYCLES = HalfCyclesDef
) (
  input  logic clk,
  input  logic Reset,
  rx_if.slave  bus
);

  localparam int unsigned TW = $clog2(BIT_CYCLES);

  rx_state_e   r_state;
  rx_state_e   w_state_next;
  logic [TW-1:0] r_timer;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_shift;
  logic        r_parity;
  logic        r_received;
  logic [7:0]  r_dout;
  logic        r_parity_err;
  logic        r_frame_err;
  logic        r_overrun;

  logic w_sin;
  logic w_half_done;
  logic w_bit_done;
  logic w_last_bit;
  logic w_clr_timer;
  logic w_clr_bit;
  logic w_inc_bit;
  logic w_shift;
  logic w_cap_par;
  logic w_done;

  rx_sync2 #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .Reset (Reset),
    .i_d   (bus.Sin),
    .o_q   (w_sin)
  );

  assign w_half_done = (r_timer == TW'(HALF_CYCLES - 1));
  assign w_bit_done  = (r_timer == TW'(BIT_CYCLES - 1));
  assign w_last_bit  = (r_bit_cnt == 3'd7);

  always_comb begin
    w_state_next = r_state;
    w_clr_timer  = 1'b0;
    w_clr_bit    = 1'b0;
    w_inc_bit    = 1'b0;
    w_shift      = 1'b0;
    w_cap_par    = 1'b0;
    w_done       = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_clr_timer = 1'b1;
        if (!w_sin) w_state_next = StStart;
      end
      StStart: begin
        if (w_half_done) begin
          // Line back high at the start-bit centre means a glitch, not a frame.
          if (w_sin) begin
            w_state_next = StIdle;
          end else begin
            w_state_next = StBits;
            w_clr_timer  = 1'b1;
            w_clr_bit    = 1'b1;
          end
        end
      end
      StBits: begin
        if (w_bit_done) begin
          w_shift     = 1'b1;
          w_clr_timer = 1'b1;
          if (w_last_bit) w_state_next = StPar;
          else            w_inc_bit    = 1'b1;
        end
      end
      StPar: begin
        if (w_bit_done) begin
          w_cap_par    = 1'b1;
          w_clr_timer  = 1'b1;
          w_state_next = StStop;
        end
      end
      StStop: begin
        if (w_bit_done) begin
          w_done       = 1'b1;
          w_clr_timer  = 1'b1;
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_state   <= StIdle;
      r_timer   <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_parity  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_clr_timer) r_timer <= '0;
      else             r_timer <= r_timer + TW'(1);
      if (w_clr_bit)      r_bit_cnt <= '0;
      else if (w_inc_bit) r_bit_cnt <= r_bit_cnt + 3'd1;
      if (w_shift)   r_shift[r_bit_cnt] <= w_sin;
      if (w_cap_par) r_parity <= w_sin;
    end
  end

  // Completion takes priority over a coincident ack so no byte is silently lost.
  always_ff @(posedge clk) begin
    if (Reset) begin
      r_received   <= 1'b0;
      r_dout       <= '0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
    end else if (w_done) begin
      r_dout       <= r_shift;
      r_parity_err <= ~^{r_shift, r_parity};
      r_frame_err  <= ~w_sin;
      r_overrun    <= r_received;
      r_received   <= 1'b1;
    end else if (bus.ReceiveAck) begin
      r_received <= 1'b0;
      r_overrun  <= 1'b0;
    end
  end

  assign bus.Received  = r_received;
  assign bus.Dout      = r_dout;
  assign bus.parityErr = r_parity_err;
  assign bus.frameErr  = r_frame_err;
  assign bus.overrun   = r_overrun;

endmodule
